// File: rtl/servo_angle_ramp.sv
// Servo angle ramp: accepts a target joint angle over valid/ready and slews the
// commanded angle toward it by at most STEP per PWM-frame tick. It then holds
// for SETTLE_TICKS ticks and pulses done, so downstream servo controllers never
// see a step jump. Angles are signed Q11.7 degrees.
module servo_angle_ramp #(
  parameter int                 CLK_HZ       = 50_000_000,
  parameter int                 UPDATE_HZ    = 50,
  parameter logic signed [17:0] STEP         = 18'sd256,
  parameter logic signed [17:0] ANGLE_MIN    = -18'sd11520,
  parameter logic signed [17:0] ANGLE_MAX    = 18'sd11520,
  parameter int                 SETTLE_TICKS = 5
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               enable_in,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic signed [17:0] cmd_angle,
  output logic signed [17:0] angle,
  output logic               en,
  output logic               busy,
  output logic               done
);

  localparam int TICK_DIV = CLK_HZ / UPDATE_HZ;
  localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  localparam int SETTLE_W = $clog2(SETTLE_TICKS + 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_TICKS - 1);

  localparam logic signed [18:0] STEP_WIDE = 19'(STEP);

  typedef enum logic [1:0] {
    IDLE,
    RAMP,
    SETTLE
  } state_t;

  state_t                 state;
  logic [TICK_W-1:0]      tick_cnt;
  logic                   tick;
  logic [SETTLE_W-1:0]    settle_cnt;
  logic signed [17:0]     target;
  logic signed [17:0]     clamped;
  logic signed [18:0]     diff;
  logic signed [18:0]     abs_diff;
  logic                   accept;

  assign tick      = (tick_cnt == TICK_LAST);
  assign cmd_ready = enable_in && (state == IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state != IDLE);

  // Free-running frame divider; keeps counting in every state so ticks stay aligned to PWM frames.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  // Clamp the offered target and form the 19-bit distance still to travel.
  always_comb begin
    clamped = cmd_angle;
    if (cmd_angle < ANGLE_MIN) begin
      clamped = ANGLE_MIN;
    end else if (cmd_angle > ANGLE_MAX) begin
      clamped = ANGLE_MAX;
    end
    diff     = 19'(target) - 19'(angle);
    abs_diff = diff[18] ? -diff : diff;
  end

  // Motion FSM: accept a target, step once per tick until reached, hold, then pulse done.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      angle      <= '0;
      en         <= 1'b0;
      done       <= 1'b0;
      target     <= '0;
      settle_cnt <= '0;
    end else begin
      done <= 1'b0;
      if (!enable_in) begin
        state <= IDLE;
        en    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              target     <= clamped;
              en         <= 1'b1;
              settle_cnt <= '0;
              state      <= (clamped != angle) ? RAMP : SETTLE;
            end
          end
          RAMP: begin
            if (tick) begin
              if (abs_diff <= STEP_WIDE) begin
                angle      <= target;
                settle_cnt <= '0;
                state      <= SETTLE;
              end else if (diff[18]) begin
                angle <= angle - STEP;
              end else begin
                angle <= angle + STEP;
              end
            end
          end
          SETTLE: begin
            if (tick) begin
              if (settle_cnt == SETTLE_LAST) begin
                settle_cnt <= '0;
                done       <= 1'b1;
                state      <= IDLE;
              end else begin
                settle_cnt <= settle_cnt + SETTLE_W'(1);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_servo_angle_ramp.sv
// Testbench for servo_angle_ramp with a 10-cycle tick and 5-tick settle.
// A table of moves is replayed back to back, followed by enable and reset abort sequences.
module tb_servo_angle_ramp;

  logic               clock = 1'b0;
  logic               reset_n;
  logic               enable_in;
  logic               cmd_valid;
  logic               cmd_ready;
  logic signed [17:0] cmd_angle;
  logic signed [17:0] angle;
  logic               en;
  logic               busy;
  logic               done;

  int check_count = 0;
  int pass_count  = 0;

  typedef struct {
    logic signed [17:0] cmd;
    logic signed [17:0] target;
    int                 steps;
    string              name;
  } vec_t;

  vec_t vecs[8];

  servo_angle_ramp #(
    .CLK_HZ      (1000),
    .UPDATE_HZ   (100),
    .STEP        (18'sd256),
    .ANGLE_MIN   (-18'sd11520),
    .ANGLE_MAX   (18'sd11520),
    .SETTLE_TICKS(5)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .enable_in(enable_in),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_angle(cmd_angle),
    .angle    (angle),
    .en       (en),
    .busy     (busy),
    .done     (done)
  );

  // 10-unit clock period
  always #5 clock = ~clock;

  // Global time limit so the run always ends
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

  task automatic check_output(input string name, input int actual, input int expected);
    check_count++;
    if (actual == expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Offer a command and hold valid until the accepting edge has passed
  task automatic apply_stimulus(input logic signed [17:0] cmd);
    @(negedge clock);
    cmd_angle = cmd;
    cmd_valid = 1'b1;
    for (int i = 0; i < 100 && !cmd_ready; i++) @(negedge clock);
    check_output("cmd_ready_at_offer", int'(cmd_ready), 1);
    @(posedge clock);
    #1 cmd_valid = 1'b0;
  endtask

  // Run a full move, timing every angle change relative to the accepting edge
  task automatic run_move(input logic signed [17:0] cmd, input logic signed [17:0] exp_target,
                          input int exp_steps, input string tag);
    int steps = 0;
    int cyc = 0;
    int first_change = -1;
    int last_change = 0;
    int done_cyc = -1;
    int delta;
    logic signed [17:0] prev;
    prev = angle;
    apply_stimulus(cmd);
    while (cyc < 3000 && done_cyc < 0) begin
      @(negedge clock);
      cyc++;
      if (cyc == 1) check_output({tag, "/busy_after_accept"}, int'(busy), 1);
      if (angle != prev) begin
        steps++;
        delta = int'(angle) - int'(prev);
        check_output({tag, "/step_size"}, int'(delta <= 256 && delta >= -256), 1);
        check_output({tag, "/angle_in_range"}, int'(angle >= -11520 && angle <= 11520), 1);
        if (first_change < 0) first_change = cyc;
        else check_output({tag, "/step_spacing"}, cyc - last_change, 10);
        last_change = cyc;
        prev = angle;
      end
      if (done) done_cyc = cyc;
    end
    check_output({tag, "/done_seen"}, int'(done_cyc >= 0), 1);
    check_output({tag, "/step_count"}, steps, exp_steps);
    check_output({tag, "/final_angle"}, int'(angle), int'(exp_target));
    if (exp_steps > 0) begin
      check_output({tag, "/first_step_latency"}, int'(first_change >= 1 && first_change <= 10), 1);
      check_output({tag, "/settle_time"}, done_cyc - last_change, 50);
    end else begin
      check_output({tag, "/settle_only_time"}, int'(done_cyc >= 41 && done_cyc <= 50), 1);
    end
    check_output({tag, "/en_at_done"}, int'(en), 1);
    @(negedge clock);
    check_output({tag, "/done_width"}, int'(done), 0);
    check_output({tag, "/busy_after_done"}, int'(busy), 0);
    check_output({tag, "/ready_after_done"}, int'(cmd_ready), 1);
  endtask

  // Start a move and return once the given number of steps has been observed
  task automatic partial_move(input logic signed [17:0] cmd, input int n_steps, input string tag);
    int steps = 0;
    logic signed [17:0] prev;
    prev = angle;
    apply_stimulus(cmd);
    for (int i = 0; i < 400 && steps < n_steps; i++) begin
      @(negedge clock);
      if (angle != prev) begin
        steps++;
        prev = angle;
      end
    end
    check_output({tag, "/partial_steps"}, steps, n_steps);
  endtask

  initial begin
    int done_hits;
    int moves;

    vecs[0] = '{18'sd7680,   18'sd7680,   30, "up60"};
    vecs[1] = '{-18'sd7680,  -18'sd7680,  60, "down120"};
    vecs[2] = '{18'sd0,      18'sd0,      30, "home"};
    vecs[3] = '{18'sd300,    18'sd300,    2,  "small"};
    vecs[4] = '{18'sd15360,  18'sd11520,  44, "clamp_hi"};
    vecs[5] = '{18'sd15360,  18'sd11520,  0,  "same_angle"};
    vecs[6] = '{-18'sd15360, -18'sd11520, 90, "clamp_lo"};
    vecs[7] = '{18'sd0,      18'sd0,      45, "home2"};

    reset_n   = 1'b1;
    enable_in = 1'b1;
    cmd_valid = 1'b0;
    cmd_angle = '0;

    // Asynchronous reset asserted mid-cycle, checked before any edge
    #22 reset_n = 1'b0;
    #1;
    check_output("reset/angle", int'(angle), 0);
    check_output("reset/en", int'(en), 0);
    check_output("reset/busy", int'(busy), 0);
    check_output("reset/done", int'(done), 0);
    check_output("reset/cmd_ready", int'(cmd_ready), 1);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check_output("post_reset/angle", int'(angle), 0);
    check_output("post_reset/busy", int'(busy), 0);

    for (int v = 0; v < 8; v++) begin
      run_move(vecs[v].cmd, vecs[v].target, vecs[v].steps, vecs[v].name);
    end

    // Enable drop mid-move freezes the angle and returns to idle without done
    partial_move(18'sd7680, 10, "abort_en");
    check_output("abort_en/angle_at_drop", int'(angle), 2560);
    enable_in = 1'b0;
    @(negedge clock);
    check_output("abort_en/en", int'(en), 0);
    check_output("abort_en/busy", int'(busy), 0);
    check_output("abort_en/cmd_ready", int'(cmd_ready), 0);
    cmd_angle = '0;
    cmd_valid = 1'b1;
    done_hits = 0;
    moves = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (done) done_hits++;
      if (angle != 18'sd2560) moves++;
      if (busy) moves++;
    end
    check_output("abort_en/no_done", done_hits, 0);
    check_output("abort_en/frozen", moves, 0);
    cmd_valid = 1'b0;
    enable_in = 1'b1;
    @(negedge clock);
    check_output("abort_en/ready_reenabled", int'(cmd_ready), 1);
    check_output("abort_en/en_until_accept", int'(en), 0);
    run_move(18'sd0, 18'sd0, 10, "reenable");

    // Reset pulse mid-move aborts immediately
    partial_move(18'sd7680, 10, "abort_rst");
    #2 reset_n = 1'b0;
    #1;
    check_output("abort_rst/angle", int'(angle), 0);
    check_output("abort_rst/en", int'(en), 0);
    check_output("abort_rst/busy", int'(busy), 0);
    @(negedge clock);
    reset_n = 1'b1;
    done_hits = 0;
    moves = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (done) done_hits++;
      if (angle != 18'sd0) moves++;
    end
    check_output("abort_rst/no_done", done_hits, 0);
    check_output("abort_rst/held_zero", moves, 0);
    run_move(18'sd300, 18'sd300, 2, "post_abort");

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
